lane_fifo_arbiter: RTL
======================

Name: lane_fifo_arbiter

Overview:
Round-robin read scheduler that drains NUM_LANES lane FIFOs onto one shared downstream valid/ready output. It drives each FIFO's rd_en and consumes its registered data_out/rd_ack (1-cycle read latency). Each output word carries the source lane index. Per-lane bursts are bounded so no single lane starves the others.

Parameters:
NUM_LANES, 4, number of lane FIFOs arbitrated (>=2)
FIFO_WIDTH, 32, data width of each lane FIFO and of out_data
MAX_BURST, 4, max words read from one lane per grant (>=1)
LANE_W, $clog2(NUM_LANES), width of lane index (derived, not overridden)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  arbitration enable; 0 = start no new grant
lane_mask  in  NUM_LANES  1 = lane eligible for grant
lane_empty  in  NUM_LANES  empty flag from each FIFO
lane_rd_en  out  NUM_LANES  one-hot read enable to each FIFO
lane_rd_ack  in  NUM_LANES  rd_ack from each FIFO
lane_data  in  NUM_LANES*FIFO_WIDTH  data_out of each FIFO, lane i at [i*FIFO_WIDTH +: FIFO_WIDTH]
out_valid  out  1  output word valid
out_ready  in  1  downstream accept
out_data  out  FIFO_WIDTH  output word
out_lane  out  LANE_W  source lane of out_data
grant  out  NUM_LANES  one-hot currently granted lane, 0 in IDLE
ack_err  out  1  one-cycle pulse: read issued but no rd_ack returned

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rr_ptr=0, burst_cnt=0, cur_lane=0; all outputs 0 (lane_rd_en, out_valid, out_data, out_lane, grant, ack_err). Reset mid-burst drops any held word; no rd_en is issued while rst_n=0.
- FSM states: IDLE, READ, CAPTURE, HOLD. All outputs registered or decoded from state only (no combinational in->out paths).
- IDLE: eligible[i] = lane_mask[i] & ~lane_empty[i]. If enable and any eligible: cur_lane = first eligible scanning rr_ptr, rr_ptr+1, ... mod NUM_LANES; burst_cnt<=0; -> READ. Otherwise stay.
- READ (1 cycle): lane_rd_en[cur_lane]=1, other bits 0; -> CAPTURE.
- CAPTURE: if lane_rd_ack[cur_lane]: out_data<=lane_data[cur_lane], out_lane<=cur_lane, out_valid<=1; -> HOLD. Else ack_err pulses high for the following cycle, rr_ptr<=cur_lane+1 mod NUM_LANES; -> IDLE.
- HOLD: out_valid, out_data and out_lane stable until out_ready=1. On out_valid&out_ready: out_valid<=0, burst_cnt<=burst_cnt+1. Continue (-> READ) iff burst_cnt+1<MAX_BURST and enable and lane_mask[cur_lane] and ~lane_empty[cur_lane]. Else -> IDLE, rr_ptr<=cur_lane+1 mod NUM_LANES.
- grant = one-hot(cur_lane) in READ, CAPTURE, HOLD; 0 in IDLE.
- Latency: IDLE with eligible lane at edge t -> rd_en high in cycle t+1 -> out_valid high from cycle t+3. Peak throughput is 1 word / 3 cycles with out_ready=1.
- Exactly one lane_rd_en bit high at a time, and only in READ. No read is issued while a word is held. The output never overflows, and no FIFO word is lost under backpressure.
- Mask or enable deassertion mid-burst: the current held word still completes; the burst ends at the HOLD exit.
- rr_ptr wrap: NUM_LANES-1 -> 0. Non-power-of-2 NUM_LANES supported by explicit compare, not bit truncation.
- burst_cnt width $clog2(MAX_BURST+1); never exceeds MAX_BURST.

Decomposition:
- Package lane_arb_pkg: state enum (IDLE, READ, CAPTURE, HOLD), typedef lane_idx_t [LANE_W-1:0].
- Sub-module rr_pick: combinational rotate-priority encoder. Inputs: eligible vector, rr_ptr. Outputs: any, idx.

Test Plan:
- Single lane: lane 2 holds 3 words A,B,C, others empty, out_ready=1 -> outputs A,B,C with out_lane=2, first out_valid 3 cycles after leaving IDLE, one word per 3 cycles, then IDLE with rr_ptr=3.
- Fairness: all 4 lanes hold 10 words, MAX_BURST=4 -> lane order 0x4, 1x4, 2x4, 3x4, 0x4..., never more than 4 consecutive from one lane.
- Backpressure: out_ready=0 for 7 cycles in HOLD -> out_data/out_lane stable, no lane_rd_en pulse; after out_ready=1 the next word is read. Zero words lost or duplicated.
- Mask/enable: clear lane_mask[1] mid-burst -> held word delivered, burst ends, lane 1 skipped thereafter; enable=0 in IDLE -> no rd_en.
- Missing ack: force lane_rd_ack[0]=0 after READ -> ack_err pulses once, out_valid stays 0, next grant goes to lane 1.
- Reset mid-HOLD: rst_n=0 while out_valid=1 -> all outputs 0 immediately; after release, arbitration restarts at lane 0.

Source files
------------

// File: rtl/lane_arb_pkg.sv
// Shared types for the lane FIFO read arbiter: FSM state encoding and
// the lane index type for the default four-lane configuration.
package lane_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      READ    = 2'd1,
      CAPTURE = 2'd2,
      HOLD    = 2'd3
   } state_e;

   localparam int PKG_NUM_LANES = 4;
   localparam int PKG_LANE_W    = $clog2(PKG_NUM_LANES);

   typedef logic [PKG_LANE_W-1:0] lane_idx_t;

endpackage

// File: rtl/lane_fifo_arbiter_rr_pick.sv
// Rotating-priority encoder: returns the first set bit of eligible_i,
// scanning upward from rr_ptr_i and wrapping past the top lane.
module rr_pick #(
   parameter int N  = 4,
   parameter int LW = $clog2(N)
) (
   input  logic [N-1:0]  eligible_i,
   input  logic [LW-1:0] rr_ptr_i,
   output logic          any_o,
   output logic [LW-1:0] idx_o
);

   // Wrap by explicit compare so non-power-of-2 lane counts stay in range.
   function automatic logic [LW-1:0] wrap_add(input logic [LW-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= N) s = s - N;
      return LW'(s);
   endfunction

   always_comb begin
      any_o = |eligible_i;
      idx_o = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (eligible_i[wrap_add(rr_ptr_i, k)]) idx_o = wrap_add(rr_ptr_i, k);
      end
   end

endmodule

// File: rtl/lane_fifo_arbiter.sv
// Round-robin drain of NUM_LANES registered-output FIFOs onto one
// valid/ready stream, with bounded bursts and a missing-ack error pulse.
module lane_fifo_arbiter
   import lane_arb_pkg::*;
#(
   parameter int  NUM_LANES  = 4,
   parameter int  FIFO_WIDTH = 32,
   parameter int  MAX_BURST  = 4,
   localparam int LANE_W     = $clog2(NUM_LANES)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            enable,
   input  logic [NUM_LANES-1:0]            lane_mask,
   input  logic [NUM_LANES-1:0]            lane_empty,
   output logic [NUM_LANES-1:0]            lane_rd_en,
   input  logic [NUM_LANES-1:0]            lane_rd_ack,
   input  logic [NUM_LANES*FIFO_WIDTH-1:0] lane_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [FIFO_WIDTH-1:0]           out_data,
   output logic [LANE_W-1:0]               out_lane,
   output logic [NUM_LANES-1:0]            grant,
   output logic                            ack_err
);

   localparam int BCW = $clog2(MAX_BURST + 1);

   state_e                  state_q, state_d;
   logic [LANE_W-1:0]       cur_lane_q, cur_lane_d;
   logic [LANE_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [BCW-1:0]          burst_cnt_q, burst_cnt_d;
   logic                    out_valid_q, out_valid_d;
   logic [FIFO_WIDTH-1:0]   out_data_q, out_data_d;
   logic [LANE_W-1:0]       out_lane_q, out_lane_d;
   logic                    ack_err_q, ack_err_d;

   logic [NUM_LANES-1:0]    eligible;
   logic                    pick_any;
   logic [LANE_W-1:0]       pick_idx;
   logic [LANE_W-1:0]       lane_next;
   logic [BCW-1:0]          burst_inc;
   logic                    cont_burst;

   assign eligible  = lane_mask & ~lane_empty;
   assign lane_next = (cur_lane_q == LANE_W'(NUM_LANES - 1)) ? '0 : cur_lane_q + 1'b1;
   assign burst_inc = burst_cnt_q + 1'b1;
   assign cont_burst = (burst_inc < BCW'(MAX_BURST)) && enable &&
                       lane_mask[cur_lane_q] && !lane_empty[cur_lane_q];

   rr_pick #(
      .N  (NUM_LANES),
      .LW (LANE_W)
   ) u_pick (
      .eligible_i (eligible),
      .rr_ptr_i   (rr_ptr_q),
      .any_o      (pick_any),
      .idx_o      (pick_idx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cur_lane_q  <= '0;
         rr_ptr_q    <= '0;
         burst_cnt_q <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_lane_q  <= '0;
         ack_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_lane_q  <= cur_lane_d;
         rr_ptr_q    <= rr_ptr_d;
         burst_cnt_q <= burst_cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_lane_q  <= out_lane_d;
         ack_err_q   <= ack_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cur_lane_d  = cur_lane_q;
      rr_ptr_d    = rr_ptr_q;
      burst_cnt_d = burst_cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_lane_d  = out_lane_q;
      ack_err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (enable && pick_any) begin
               cur_lane_d  = pick_idx;
               burst_cnt_d = '0;
               state_d     = READ;
            end
         end
         READ: state_d = CAPTURE;
         CAPTURE: begin
            if (lane_rd_ack[cur_lane_q]) begin
               out_data_d  = lane_data[int'(cur_lane_q)*FIFO_WIDTH +: FIFO_WIDTH];
               out_lane_d  = cur_lane_q;
               out_valid_d = 1'b1;
               state_d     = HOLD;
            end else begin
               ack_err_d = 1'b1;
               rr_ptr_d  = lane_next;
               state_d   = IDLE;
            end
         end
         HOLD: begin
            // A held word always completes; mask/enable only decide what follows it.
            if (out_ready) begin
               out_valid_d = 1'b0;
               burst_cnt_d = burst_inc;
               if (cont_burst) begin
                  state_d = READ;
               end else begin
                  rr_ptr_d = lane_next;
                  state_d  = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      lane_rd_en = '0;
      grant      = '0;
      if (state_q != IDLE) grant[cur_lane_q] = 1'b1;
      if (state_q == READ) lane_rd_en[cur_lane_q] = 1'b1;
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_lane  = out_lane_q;
   assign ack_err   = ack_err_q;

endmodule
